nibble_serial_add_ctrl: RTL and testbench

- Sequencer that adds two WIDTH-bit operands by time-sharing one 4-bit adder slice, one nibble per clock, LSB nibble first.
- The nibble carry is registered between cycles.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades latency for area against a full-width ripple adder.

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 14 +
 rtl/nibble_serial_add_ctrl_if.sv | 34 +++
 rtl/nibble_serial_add_ctrl_nibble_add4.sv | 20 ++
 rtl/nibble_serial_add_ctrl.sv | 112 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// rtl/nibble_serial_add_ctrl_pkg.sv - shared types and constants for the nibble-serial adder
package nibble_serial_add_ctrl_pkg;

  // Width of the shared adder slice.
  localparam int NIBBLE_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// rtl/nibble_serial_add_ctrl_if.sv - operand/result handshake bundle for the nibble-serial adder
//
// Signals:
//   in_valid/in_ready  operand handshake; a, b, cin qualify it.
//   out_valid/out_ready result handshake; sum, cout qualify it.
//   busy               controller is in RUN or DONE.
// The master modport is the producer/consumer side. The slave modport is the controller.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  import nibble_serial_add_ctrl_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/nibble_serial_add_ctrl_nibble_add4.sv
// rtl/nibble_serial_add_ctrl_nibble_add4.sv - combinational 4-bit adder slice with carry in/out
//
// Ports:
//   a, b  (in, 4)  addend nibbles
//   ci    (in, 1)  carry in
//   s     (out, 4) sum nibble
//   co    (out, 1) carry out
module nibble_add4
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - WIDTH-bit adder that time-shares one 4-bit slice, LSB nibble first
//
// Ports:
//   clk  (in)  system clock, rising edge.
//   rst  (in)  synchronous, active-high reset.
//   bus  (slave modport of nibble_serial_add_ctrl_if)
//        in_valid/in_ready, a, b, cin   operand handshake
//        out_valid/out_ready, sum, cout result handshake, registered result
//        busy                           high in RUN and DONE
// The controller takes NIB = WIDTH/4 cycles in RUN and one or more cycles in DONE.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  nibble_serial_add_ctrl_if.slave bus
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, b_q, result_q;
  logic                 carry_q, cout_q;
  logic [IDX_W-1:0]     idx_q;
  logic [NIBBLE_W-1:0]  slice_s;
  logic                 slice_co;
  logic                 last_nib;
  logic                 in_ready_c, out_valid_c, busy_c;
  // Result register with the new nibble concatenated on top. Taking the upper WIDTH
  // bits gives the right shift, and this also works when WIDTH equals one nibble.
  logic [WIDTH+NIBBLE_W-1:0] shifted;

  nibble_add4 u_slice (
    .a  (a_q[NIBBLE_W-1:0]),
    .b  (b_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  assign last_nib = (idx_q == IDX_W'(NIB - 1));
  assign shifted  = {slice_s, result_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_nib) state_d = DONE;
      end
      DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          a_q      <= a_q >> NIBBLE_W;
          b_q      <= b_q >> NIBBLE_W;
          carry_q  <= slice_co;
          result_q <= shifted[WIDTH+NIBBLE_W-1:NIBBLE_W];
          idx_q    <= idx_q + IDX_W'(1);
          if (last_nib) cout_q <= slice_co;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.sum       = result_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed self-checking bench for nibble_serial_add_ctrl
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl_if #(.WIDTH(16)) bus16 ();
  nibble_serial_add_ctrl_if #(.WIDTH(4))  bus4 ();

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  nibble_serial_add_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic do_op16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         output int lat);
    bus16.a = av; bus16.b = bv; bus16.cin = cv; bus16.in_valid = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    bus16.a = 16'hDEAD; bus16.b = 16'hBEEF; bus16.cin = ~cv;
    lat = 0;
    while (!bus16.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release16();
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
    bus16.a = 16'h1111; bus16.b = 16'h2222; bus16.cin = 1'b1;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    bus4.a = 4'h0; bus4.b = 4'h0; bus4.cin = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus16.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus16.in_ready); end
    checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus16.out_valid); end
    checks++; if (bus16.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus16.busy); end
    checks++; if (bus16.sum !== 16'h0000 || bus16.cout !== 1'b0) begin errors++; $display("FAIL reset_sum got=%h/%b exp=0000/0", bus16.sum, bus16.cout); end
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus16.busy !== 1'b0 || bus16.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_idle busy=%b in_ready=%b exp=0/1", bus16.busy, bus16.in_ready); end
  endtask

  task automatic test_basic_latency();
    int lat;
    do_op16(16'h0001, 16'h0002, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++; if (bus16.sum !== 16'h0003 || bus16.cout !== 1'b0) begin errors++; $display("FAIL basic_sum got=%h/%b exp=0003/0", bus16.sum, bus16.cout); end
    checks++; if (bus16.busy !== 1'b1 || bus16.in_ready !== 1'b0) begin errors++; $display("FAIL basic_done_flags busy=%b in_ready=%b exp=1/0", bus16.busy, bus16.in_ready); end
    release16();
    checks++; if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin errors++; $display("FAIL basic_release out_valid=%b in_ready=%b exp=0/1", bus16.out_valid, bus16.in_ready); end
  endtask

  task automatic test_carry_chain();
    int lat;
    do_op16(16'hFFFF, 16'h0001, 1'b0, lat);
    checks++; if (lat !== 4 || bus16.sum !== 16'h0000 || bus16.cout !== 1'b1) begin errors++; $display("FAIL carry_chain lat=%0d sum=%h cout=%b exp=4/0000/1", lat, bus16.sum, bus16.cout); end
    release16();
    do_op16(16'hFFFF, 16'hFFFF, 1'b1, lat);
    checks++; if (bus16.sum !== 16'hFFFF || bus16.cout !== 1'b1) begin errors++; $display("FAIL all_ones got=%h/%b exp=ffff/1", bus16.sum, bus16.cout); end
    release16();
  endtask

  task automatic test_backpressure();
    int lat;
    do_op16(16'h1234, 16'h4321, 1'b1, lat);
    bus16.a = 16'h1111; bus16.b = 16'h1111; bus16.cin = 1'b0; bus16.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0 || bus16.sum !== 16'h5556 || bus16.cout !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold cyc=%0d out_valid=%b in_ready=%b sum=%h cout=%b exp=1/0/5556/0", i, bus16.out_valid, bus16.in_ready, bus16.sum, bus16.cout);
      end
      @(negedge clk);
    end
    bus16.in_valid = 1'b0;
    release16();
    @(negedge clk);
    checks++; if (bus16.busy !== 1'b0 || bus16.in_ready !== 1'b1) begin errors++; $display("FAIL no_stall_memory busy=%b in_ready=%b exp=0/1", bus16.busy, bus16.in_ready); end
    do_op16(16'h0F0F, 16'h0101, 1'b0, lat);
    checks++; if (bus16.sum !== 16'h1010 || bus16.cout !== 1'b0) begin errors++; $display("FAIL after_backpressure got=%h/%b exp=1010/0", bus16.sum, bus16.cout); end
    release16();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    bus16.a = 16'h8765; bus16.b = 16'h4321; bus16.cin = 1'b1; bus16.in_valid = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus16.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus16.out_ready = 1'b0;
    checks++;
    if (bus16.out_valid !== 1'b0 || bus16.sum !== 16'h0000 || bus16.in_ready !== 1'b1 || bus16.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run out_valid=%b sum=%h in_ready=%b busy=%b exp=0/0000/1/0", bus16.out_valid, bus16.sum, bus16.in_ready, bus16.busy);
    end
    do_op16(16'h00AA, 16'h0055, 1'b0, lat);
    checks++; if (lat !== 4 || bus16.sum !== 16'h00FF || bus16.cout !== 1'b0) begin errors++; $display("FAIL after_reset_op lat=%0d sum=%h cout=%b exp=4/00ff/0", lat, bus16.sum, bus16.cout); end
    release16();
  endtask

  task automatic test_back_to_back();
    int lat;
    bus16.out_ready = 1'b1;
    do_op16(16'h7000, 16'h9000, 1'b0, lat);
    checks++; if (lat !== 4 || bus16.sum !== 16'h0000 || bus16.cout !== 1'b1) begin errors++; $display("FAIL b2b_first lat=%0d sum=%h cout=%b exp=4/0000/1", lat, bus16.sum, bus16.cout); end
    @(negedge clk);
    checks++; if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_done_one_cycle out_valid=%b in_ready=%b exp=0/1", bus16.out_valid, bus16.in_ready); end
    do_op16(16'h0123, 16'h0456, 1'b1, lat);
    checks++; if (lat !== 4 || bus16.sum !== 16'h057A || bus16.cout !== 1'b0) begin errors++; $display("FAIL b2b_second lat=%0d sum=%h cout=%b exp=4/057a/0", lat, bus16.sum, bus16.cout); end
    @(negedge clk);
    bus16.out_ready = 1'b0;
  endtask

  task automatic test_width4();
    int lat;
    bus4.a = 4'hA; bus4.b = 4'h5; bus4.cin = 1'b1; bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0; bus4.cin = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 1) begin errors++; $display("FAIL w4_latency got=%0d exp=1", lat); end
    checks++; if (bus4.sum !== 4'h0 || bus4.cout !== 1'b1) begin errors++; $display("FAIL w4_sum got=%h/%b exp=0/1", bus4.sum, bus4.cout); end
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
    checks++; if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin errors++; $display("FAIL w4_release out_valid=%b in_ready=%b exp=0/1", bus4.out_valid, bus4.in_ready); end
  endtask

  initial begin
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
    bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_latency();
    test_carry_chain();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_width4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
